hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Consumes the per-instruction register usage (destination, source 1, source 2) produced by decode.
- Tracks destination registers of instructions in flight in EX, MEM and WB.
- Drives the decode-stage stall and the operand forwarding selects for the RV32I 5-stage pipeline.
- Sits between decode and the ID/EX pipeline register.

Parameters:
- FORWARD, 1: 1 = forwarding network present (stall only on load-use); 0 = no forwarding (stall until the producer leaves MEM).
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  decode slot holds a real instruction
- id_written_reg  input  5  destination register of the decode instruction; 0 = none
- id_read_reg1  input  5  source register 1; 0 = unused
- id_read_reg2  input  5  source register 2; 0 = unused
- id_is_load  input  1  decode instruction is a load (opcode 0000011)
- flush  input  1  branch/jump redirect; kill the decode instruction
- pipe_hold  input  1  global freeze (memory wait); no stage advances
- stall  output  1  hold PC and IF/ID, insert bubble into EX
- fwd_sel1  output  2  source-1 operand select: 00 regfile, 01 EX result, 10 MEM result, 11 WB result
- fwd_sel2  output  2  source-2 operand select, same encoding
- stall_count  output  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset is asynchronous and active-low, on rst_n with clock clk.
- State: three entries EX, MEM, WB, each holding {valid, rd[4:0], is_load}.
- Reset values: all entries valid=0, rd=0, is_load=0; stall_count=0.
  - Outputs under reset: stall=0 and fwd_sel1/2=00, because the outputs are combinational from empty entries.
- Match rule: source r matches stage S iff r!=0 AND S.valid AND S.rd==r. A register x0 never matches.
- The stall and fwd_sel outputs are combinational from the current ID inputs and the registered entries, with zero-cycle latency.
- When id_valid=0: stall=0 and fwd_sel=00.
- FORWARD=1:
  - stall=1 iff either source matches EX and EX.is_load=1 (load-use).
  - fwd_selN is priority-encoded, youngest first: EX match -> 01, else MEM match -> 10, else WB match -> 11, else 00.
  - While stall=1, fwd_sel outputs are don't-care; the bench ignores them.
- FORWARD=0:
  - stall=1 iff either source matches EX or MEM.
  - A WB match needs no stall, because the regfile is write-first.
  - fwd_sel1/2 are tied to 00.
- Advance, on every rising clk with pipe_hold=0:
  - WB<=MEM and MEM<=EX.
  - EX<={valid=id_valid & ~stall & ~flush & (id_written_reg!=0), rd=id_written_reg, is_load=id_is_load}.
  - Otherwise EX receives a bubble (all zero).
- pipe_hold=1: all entries hold and stall_count holds. stall and fwd_sel still reflect the current inputs.
- Flush: kills only the decode instruction, which enters EX as a bubble. Flush has priority over stall.
  - In-flight EX/MEM/WB entries are unaffected and still drain.
- stall_count increments by 1 on each advancing edge where stall=1 and flush=0.
  - It saturates at all-ones and never wraps.
- Destination x0: the instruction is tracked as invalid and never causes a stall or a forward.
- Same register on both sources: both selects resolve identically, and a single stall results.
- Reset asserted mid-operation: all entries clear immediately (asynchronously).
  - The first cycle after release sees an empty pipeline.

Test Plan:
- FORWARD=1, ALU forwarding:
  - Stimulus: addi x5 (rd=5, not load) followed next cycle by add with rs1=5, rs2=5.
  - Required: stall=0, fwd_sel1=fwd_sel2=01.
  - Third instruction reads x5: fwd=10. Fourth: fwd=11. Fifth: fwd=00.
- FORWARD=1, load-use:
  - Stimulus: lw rd=7, then an instruction with rs2=7.
  - Required: stall=1 for exactly one cycle, with a bubble in EX; next cycle stall=0 and fwd_sel2=10.
  - Required: stall_count=1.
- FORWARD=0, stall then regfile read:
  - Stimulus: rd=3 producer immediately followed by a reader of rs1=3.
  - Required: stall=1 for 2 cycles, then stall=0 with fwd_sel1=00 while the producer is in WB.
  - Required: stall_count=2.
- x0 destination:
  - Stimulus: producer with rd=0, then a reader with rs1=0 and rs2=0.
  - Required: stall=0 and fwd=00 on every cycle, including an is_load producer.
- Flush during a load-use stall:
  - Stimulus: lw rd=9, then a reader of rs1=9 with flush=1 on the same cycle.
  - Required: EX receives a bubble and stall_count is unchanged.
  - Required: the following unrelated instruction sees MEM=lw, i.e. a rs1=9 reader gets fwd=10.
- pipe_hold and async reset:
  - Stimulus: hold for 3 cycles with the pipeline full.
  - Required: entries are frozen and stall_count is unchanged.
  - Stimulus: pulse rst_n low mid-cycle.
  - Required: stall=0 and fwd=00 immediately, and stall_count=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the RV32I 5-stage pipeline.
// Tracks destinations in flight in EX/MEM/WB and produces the decode stall
// and the operand forwarding selects for the instruction sitting in ID.
module hazard_scoreboard #(
  parameter bit          FORWARD = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_written_reg,
  input  logic [4:0]       id_read_reg1,
  input  logic [4:0]       id_read_reg2,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             pipe_hold,
  output logic             stall,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EX  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'b10;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, rd: '0, is_load: 1'b0};

  stage_t ex_q, mem_q, wb_q;
  stage_t ex_d;

  logic r1_ex, r1_mem, r1_wb;
  logic r2_ex, r2_mem, r2_wb;
  logic hazard;
  logic stall_c;
  logic [SEL_W-1:0] sel1_c, sel2_c;
  logic cnt_sat;

  // A source matches a stage only for a nonzero register held by a live entry.
  function automatic logic src_hit(input logic [REG_W-1:0] r, input stage_t s);
    return (r != '0) && s.valid && (s.rd == r);
  endfunction

  // Youngest producer wins when several stages hold the same destination.
  function automatic logic [SEL_W-1:0] pick_sel(input logic ex, input logic mem,
                                                input logic wb);
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    if (ex)       sel = SEL_EX;
    else if (mem) sel = SEL_MEM;
    else if (wb)  sel = SEL_WB;
    return sel;
  endfunction

  // Source/stage match vectors against the registered in-flight entries.
  always_comb begin
    r1_ex  = src_hit(id_read_reg1, ex_q);
    r1_mem = src_hit(id_read_reg1, mem_q);
    r1_wb  = src_hit(id_read_reg1, wb_q);
    r2_ex  = src_hit(id_read_reg2, ex_q);
    r2_mem = src_hit(id_read_reg2, mem_q);
    r2_wb  = src_hit(id_read_reg2, wb_q);
  end

  // Stall and forwarding selects; zero-latency from the ID inputs.
  always_comb begin
    hazard = 1'b0;
    sel1_c = SEL_RF;
    sel2_c = SEL_RF;
    if (FORWARD) begin
      // Only a load in EX cannot be forwarded in time.
      hazard = (r1_ex | r2_ex) & ex_q.is_load;
      sel1_c = pick_sel(r1_ex, r1_mem, r1_wb);
      sel2_c = pick_sel(r2_ex, r2_mem, r2_wb);
    end else begin
      // Write-first regfile covers a WB producer; EX/MEM must drain.
      hazard = r1_ex | r2_ex | r1_mem | r2_mem;
    end
    stall_c = id_valid & hazard;
    if (!id_valid) begin
      sel1_c = SEL_RF;
      sel2_c = SEL_RF;
    end
  end

  assign stall    = stall_c;
  assign fwd_sel1 = sel1_c;
  assign fwd_sel2 = sel2_c;

  // Entry captured into EX: killed by flush or stall, x0 writers untracked.
  always_comb begin
    ex_d = BUBBLE;
    if (id_valid && !stall_c && !flush && (id_written_reg != '0)) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = id_written_reg;
      ex_d.is_load = id_is_load;
    end
  end

  assign cnt_sat = (stall_count == {CNT_W{1'b1}});

  // Pipeline advance of the in-flight entries; frozen while pipe_hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (!pipe_hold) begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Saturating count of advancing cycles lost to a hazard stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (!pipe_hold && stall_c && !flush && !cnt_sat) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: forwarding, non-forwarding and
// a narrow-counter instance share the same decode stimulus.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_written_reg;
  logic [4:0] id_read_reg1;
  logic [4:0] id_read_reg2;
  logic       id_is_load;
  logic       flush;
  logic       pipe_hold;

  logic        f_stall, n_stall, s_stall;
  logic [1:0]  f_sel1, f_sel2, n_sel1, n_sel2, s_sel1, s_sel2;
  logic [15:0] f_cnt, n_cnt;
  logic [1:0]  s_cnt;

  int checks;
  int errors;

  // Scoreboard entry: which DUT, which output, expected value.
  typedef struct {
    string tag;
    int    dut;   // 0 fwd, 1 no-fwd, 2 narrow counter
    int    kind;  // 0 stall, 1 sel1, 2 sel2, 3 count
    int    value;
  } exp_t;

  exp_t sb[$];

  hazard_scoreboard #(.FORWARD(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_written_reg(id_written_reg),
    .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_is_load(id_is_load),
    .flush(flush), .pipe_hold(pipe_hold), .stall(f_stall), .fwd_sel1(f_sel1),
    .fwd_sel2(f_sel2), .stall_count(f_cnt));

  hazard_scoreboard #(.FORWARD(1'b0), .CNT_W(16)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_written_reg(id_written_reg),
    .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_is_load(id_is_load),
    .flush(flush), .pipe_hold(pipe_hold), .stall(n_stall), .fwd_sel1(n_sel1),
    .fwd_sel2(n_sel2), .stall_count(n_cnt));

  hazard_scoreboard #(.FORWARD(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_written_reg(id_written_reg),
    .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_is_load(id_is_load),
    .flush(flush), .pipe_hold(pipe_hold), .stall(s_stall), .fwd_sel1(s_sel1),
    .fwd_sel2(s_sel2), .stall_count(s_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int observe(input int dut, input int kind);
    int v;
    v = 0;
    case (dut)
      0: case (kind) 0: v = int'(f_stall); 1: v = int'(f_sel1); 2: v = int'(f_sel2); default: v = int'(f_cnt); endcase
      1: case (kind) 0: v = int'(n_stall); 1: v = int'(n_sel1); 2: v = int'(n_sel2); default: v = int'(n_cnt); endcase
      default: case (kind) 0: v = int'(s_stall); 1: v = int'(s_sel1); 2: v = int'(s_sel2); default: v = int'(s_cnt); endcase
    endcase
    return v;
  endfunction

  task automatic push(input string tag, input int dut, input int kind, input int value);
    exp_t e;
    e.tag = tag; e.dut = dut; e.kind = kind; e.value = value;
    sb.push_back(e);
  endtask

  // Forwarding DUT expectations; selects are don't-care while stalled, cnt<0 skips.
  task automatic exp_f(input string tag, input int st, input int s1, input int s2, input int cnt);
    push({tag, ".stall"}, 0, 0, st);
    if (st == 0) begin
      push({tag, ".sel1"}, 0, 1, s1);
      push({tag, ".sel2"}, 0, 2, s2);
    end
    if (cnt >= 0) push({tag, ".cnt"}, 0, 3, cnt);
  endtask

  // Non-forwarding DUT: selects are always regfile.
  task automatic exp_n(input string tag, input int st, input int cnt);
    push({tag, ".nstall"}, 1, 0, st);
    push({tag, ".nsel1"}, 1, 1, 0);
    push({tag, ".nsel2"}, 1, 2, 0);
    if (cnt >= 0) push({tag, ".ncnt"}, 1, 3, cnt);
  endtask

  task automatic compare_pending();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.dut, e.kind), e.value);
    end
  endtask

  task automatic drive(input logic v, input int rd, input int r1, input int r2,
                       input logic ld, input logic fl, input logic hold);
    id_valid       = v;
    id_written_reg = 5'(rd);
    id_read_reg1   = 5'(r1);
    id_read_reg2   = 5'(r2);
    id_is_load     = ld;
    flush          = fl;
    pipe_hold      = hold;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare at the falling edge, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    compare_pending();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    // Reader of x5 under reset: entries empty, nothing to match.
    drive(1'b1, 6, 5, 5, 1'b0, 1'b0, 1'b0);
    exp_f("reset", 0, 0, 0, 0);
    exp_n("reset", 0, 0);
    @(negedge clk);
    compare_pending();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Forwarding: producer x5 followed by readers at distance 1..4.
    do_reset();
    drive(1'b1, 5, 1, 0, 1'b0, 1'b0, 1'b0); exp_f("alu0", 0, 0, 0, 0); step();
    drive(1'b1, 6, 5, 5, 1'b0, 1'b0, 1'b0); exp_f("alu_ex", 0, 1, 1, 0); step();
    drive(1'b1, 8, 5, 0, 1'b0, 1'b0, 1'b0); exp_f("alu_mem", 0, 2, 0, 0); step();
    drive(1'b1, 0, 0, 5, 1'b0, 1'b0, 1'b0); exp_f("alu_wb", 0, 0, 3, 0); step();
    drive(1'b1, 9, 5, 0, 1'b0, 1'b0, 1'b0); exp_f("alu_gone", 0, 0, 0, 0); step();

    // Forwarding: load-use costs exactly one bubble.
    do_reset();
    drive(1'b1, 7, 2, 0, 1'b1, 1'b0, 1'b0); exp_f("lu_lw", 0, 0, 0, 0); step();
    drive(1'b1, 10, 0, 7, 1'b0, 1'b0, 1'b0); exp_f("lu_stall", 1, 0, 0, 0); step();
    exp_f("lu_go", 0, 0, 2, 1); step();
    idle(); exp_f("lu_idle", 0, 0, 0, 1); step();

    // No forwarding: reader waits until the producer reaches WB.
    do_reset();
    drive(1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b0); exp_n("nf_prod", 0, 0); step();
    drive(1'b1, 11, 3, 0, 1'b0, 1'b0, 1'b0); exp_n("nf_st1", 1, 0); step();
    exp_n("nf_st2", 1, 1); step();
    exp_n("nf_go", 0, 2); step();
    idle(); exp_n("nf_idle", 0, 2); step();

    // x0 destination and x0 sources never interact; idle slot is quiet.
    do_reset();
    drive(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0); exp_f("x0_lw", 0, 0, 0, 0); exp_n("x0_lw", 0, 0); step();
    drive(1'b1, 12, 0, 0, 1'b0, 1'b0, 1'b0); exp_f("x0_rd", 0, 0, 0, 0); exp_n("x0_rd", 0, 0); step();
    drive(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0); exp_f("x0_rd2", 0, 0, 0, 0); exp_n("x0_rd2", 0, 0); step();
    drive(1'b0, 0, 12, 12, 1'b0, 1'b0, 1'b0); exp_f("novalid", 0, 0, 0, 0); exp_n("novalid", 0, 0); step();

    // Flush on a load-use cycle: bubble into EX, count untouched.
    do_reset();
    drive(1'b1, 9, 0, 0, 1'b1, 1'b0, 1'b0); exp_f("fl_lw", 0, 0, 0, 0); step();
    drive(1'b1, 13, 9, 0, 1'b0, 1'b1, 1'b0); push("fl_cyc.cnt", 0, 3, 0); step();
    drive(1'b1, 14, 9, 0, 1'b0, 1'b0, 1'b0); exp_f("fl_after", 0, 2, 0, 0); step();

    // Fill the pipe with a load in EX, then freeze it.
    do_reset();
    drive(1'b1, 7, 0, 0, 1'b1, 1'b0, 1'b0); exp_f("h_lw7", 0, 0, 0, 0); step();
    drive(1'b1, 15, 0, 7, 1'b0, 1'b0, 1'b0); exp_f("h_lu", 1, 0, 0, 0); step();
    drive(1'b1, 16, 0, 0, 1'b0, 1'b0, 1'b0); exp_f("h_i16", 0, 0, 0, 1); step();
    drive(1'b1, 17, 16, 0, 1'b1, 1'b0, 1'b0); exp_f("h_lw17", 0, 1, 0, 1); step();
    drive(1'b1, 18, 17, 16, 1'b0, 1'b0, 1'b1); exp_f("hold1", 1, 0, 0, 1); step();
    exp_f("hold2", 1, 0, 0, 1); step();
    drive(1'b1, 19, 16, 0, 1'b0, 1'b0, 1'b1); exp_f("hold3", 0, 2, 0, 1); step();
    exp_f("hold4", 0, 2, 0, 1); step();
    drive(1'b1, 18, 17, 0, 1'b0, 1'b0, 1'b0); exp_f("unhold", 1, 0, 0, 1); step();
    drive(1'b1, 20, 17, 16, 1'b0, 1'b0, 1'b0); exp_f("drain", 0, 2, 3, 2); step();
    drive(1'b1, 21, 20, 17, 1'b0, 1'b0, 1'b0); exp_f("prerst", 0, 1, 3, 2);
    @(negedge clk);
    compare_pending();

    // Asynchronous reset in the middle of the low phase.
    #2;
    rst_n = 1'b0;
    #1;
    exp_f("async_rst", 0, 0, 0, 0);
    compare_pending();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_f("post_rst", 0, 0, 0, 0); step();

    // Repeated load-use pairs drive the 2-bit counter into saturation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7, 0, 0, 1'b1, 1'b0, 1'b0); step();
      drive(1'b1, 0, 0, 7, 1'b0, 1'b0, 1'b0); exp_f($sformatf("sat_st%0d", i), 1, 0, 0, i); step();
      exp_f($sformatf("sat_go%0d", i), 0, 0, 2, i + 1);
      push($sformatf("sat_cnt%0d", i), 2, 3, (i + 1 > 3) ? 3 : i + 1);
      step();
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
